// File: rtl/axi_ch_src_fifo.sv
// ---------------------------------------------------------------------------
// axi_ch_src_fifo
//
// Source-side buffer for a valid/ready channel. A producer pushes payloads
// with en/din. The buffer presents them to the channel sink in arrival order,
// with first-word fall-through on data. valid is derived only from registered
// state, so there is no combinational path from en or ready to valid. Pushes
// into a full buffer are dropped, and they set the sticky ovf flag.
//
// Optional feature: define AXI_CH_STALL_CNT_EN to build a saturating 16-bit
// counter of cycles where valid=1 and ready=0. When the macro is not defined,
// stall_cnt is tied to zero.
//
// Parameters
//   DATA_W    payload width, 1..64
//   DEPTH     number of entries, power of two, 2..16
//
// Ports
//   clk       rising-edge clock
//   anreset   asynchronous active-low reset
//   en        producer push request
//   din       producer payload
//   full      buffer holds DEPTH entries
//   level     current entry count, 0..DEPTH
//   ovf       sticky: a push was refused because the buffer was full
//   ready     channel sink acceptance
//   valid     channel payload valid
//   data      channel payload (entry at the read pointer)
//   cs        transfer pulse, valid & ready
//   stall_cnt cycles with valid=1 and ready=0 (optional, else 0)
// ---------------------------------------------------------------------------
module axi_ch_src_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     anreset,
    input  logic                     en,
    input  logic [DATA_W-1:0]        din,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ready,
    output logic                     valid,
    output logic [DATA_W-1:0]        data,
    output logic                     cs,
    output logic [15:0]              stall_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    // Every flag is decoded from the registered level. A pop in the same
    // cycle does not make room for a push, because full is taken from the
    // state before the edge.
    assign full  = (level == (AW+1)'(DEPTH));
    assign valid = (level != '0);
    assign cs    = valid & ready;
    assign push  = en & ~full;
    assign pop   = cs;
    assign data  = mem[rd_ptr];

    // Storage is not reset. Entries left behind by a reset are unreachable,
    // because the pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally, because DEPTH is a power of two. level only
    // moves when exactly one of push and pop happens.
    always_ff @(posedge clk or negedge anreset) begin
        if (!anreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (en && full) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef AXI_CH_STALL_CNT_EN
    // Counts cycles where the sink holds off a valid payload. The count
    // saturates rather than wrapping, so that a very long stall still
    // reads as large.
    always_ff @(posedge clk or negedge anreset) begin
        if (!anreset) begin
            stall_cnt <= '0;
        end else if (valid && !ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/axi_ch_src_fifo.md
AXI_CH_SRC_FIFO -- requirements
Module: axi_ch_src_fifo

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 4: buffer entries, power of two, legal range 2..16.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 anreset  input  1: reset, asynchronous assert, active low.
REQ-005 en  input  1: producer push request for din this cycle.
REQ-006 din  input  DATA_W: producer payload.
REQ-007 full  output  1: buffer holds DEPTH entries; push will be refused.
REQ-008 level  output  clog2(DEPTH)+1: current entry count, 0..DEPTH.
REQ-009 ovf  output  1: sticky flag, a push was refused because full.
REQ-010 ready  input  1: channel sink acceptance.
REQ-011 valid  output  1: channel payload valid.
REQ-012 data  output  DATA_W: channel payload.
REQ-013 cs  output  1: effective transfer pulse, combinational valid & ready.
REQ-014 stall_cnt  output  16: cycles spent with valid high and ready low (see Configuration).

Function
REQ-015 The buffer SHALL be a circular FIFO of DEPTH entries with read and write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 A push SHALL occur at a rising edge iff en=1 and full=0 (registered state before the edge), writing din at the write pointer.
REQ-017 A pop SHALL occur at a rising edge iff valid=1 and ready=1, advancing the read pointer.
REQ-018 valid SHALL be registered-state derived: valid = (level != 0); no combinational path from en or ready to valid.
REQ-019 data SHALL present the entry at the read pointer (first-word fall-through); data is don't-care while valid=0.
REQ-020 Latency: a push into an empty buffer at edge N SHALL raise valid in the cycle following edge N.
REQ-021 Once valid=1, valid and data SHALL remain stable until the cycle in which cs=1 (AXI hold rule).
REQ-022 Simultaneous push and pop SHALL leave level unchanged, both pointers advance.
REQ-023 When full=1, en=1 SHALL be refused even if a pop occurs the same cycle; ovf SHALL set at that edge.
REQ-024 ready while valid=0 SHALL have no effect; cs SHALL be 0.
REQ-025 full SHALL equal (level == DEPTH); level SHALL never exceed DEPTH nor underflow below 0.
REQ-026 ovf SHALL remain 1 once set until reset.

Reset
REQ-027 anreset=0 SHALL immediately clear pointers, level=0, valid=0, cs=0, full=0, ovf=0, stall_cnt=0, regardless of clk.
REQ-028 Reset mid-transfer SHALL discard all buffered entries; buffer storage contents need not be cleared.
REQ-029 First push SHALL be accepted at the first rising edge after anreset deasserts.

Configuration
REQ-030 With macro AXI_CH_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 at each edge where valid=1 and ready=0, saturate at 16'hFFFF, and clear only on reset.
REQ-031 Without AXI_CH_STALL_CNT_EN, stall_cnt SHALL be driven constant 0 and no counter logic shall be synthesised; all other behaviour identical.

Verification
REQ-032 Reset then push din=0xA5A5_0001 with ready=0 -> next cycle valid=1, data=0xA5A5_0001, level=1; held stable 5 cycles; ready=1 -> cs=1 one cycle, then valid=0, level=0.
REQ-033 DEPTH=4, ready=0, push 0x1..0x5 on consecutive cycles -> full=1 after fourth push, fifth refused, ovf=1; then ready=1 drains 0x1,0x2,0x3,0x4 in order, 0x5 never appears.
REQ-034 Level=2, en=1 and ready=1 same cycle for 10 cycles with incrementing din -> level stays 2, pointers wrap at least twice, output order matches input order.
REQ-035 Full buffer, en=1 and ready=1 same cycle -> pop occurs, push refused, level=3, ovf=1.
REQ-036 Level=3, assert anreset=0 between edges -> valid, level, full, ovf, stall_cnt zero immediately; after release a single push yields valid one cycle later with the new data.
REQ-037 With AXI_CH_STALL_CNT_EN: one entry, ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; without macro -> stall_cnt=0 throughout.
